// File: rtl/tour_pkg.sv
// tour_pkg: shared state, opcode, heading and response constants for the tour sequencer
package tour_pkg;
  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;
  localparam logic [3:0] MOVE = 4'h2;
  localparam logic [3:0] MOVE_FAN = 4'h3;
  localparam logic [7:0] N = 8'h00;
  localparam logic [7:0] W = 8'h3F;
  localparam logic [7:0] S = 8'h7F;
  localparam logic [7:0] E = 8'hBF;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] MV_ACK = 8'h5A;
endpackage

// File: rtl/tour_cmd_seq_if.sv
// tour_cmd_seq_if: TourLogic, UART wrapper and cmd_proc handshakes; master = sequencer, slave = environment
interface tour_cmd_seq_if #(parameter int IDX_W = 5);
  logic start_tour;
  logic [7:0] move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0] cmd_UART;
  logic cmd_rdy_UART;
  logic clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic send_resp;
  logic [7:0] resp;
  logic tour_done;
  logic err;
  modport master(
    input start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_done, err
  );
  modport slave(
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_done, err
  );
endinterface

// File: rtl/tour_cmd_seq_move_decode.sv
// move_decode: one-hot knight move -> vertical/horizontal heading and square count, plus legality
// ports: move (in, one-hot); vheading/vsquares, hheading/hsquares, legal (out)
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vheading,
  output logic [3:0] vsquares,
  output logic [7:0] hheading,
  output logic [3:0] hsquares,
  output logic       legal
);
  // masks select the move bits with dy>0, |dy|=2, dx>0, |dx|=2
  assign legal = $onehot(move);
  assign vheading = |(move & 8'h87) ? N : S;
  assign vsquares = |(move & 8'h33) ? 4'd2 : 4'd1;
  assign hheading = |(move & 8'hE1) ? E : W;
  assign hsquares = |(move & 8'hCC) ? 4'd2 : 4'd1;
endmodule

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: turns a solved knight's tour into vertical/horizontal cmd_proc commands, UART pass-through when idle
// ports: clk, rst (async active-high), bus (tour_cmd_seq_if.master)
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W = 5
) (
  input logic clk,
  input logic rst,
  tour_cmd_seq_if.master bus
);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic tour_done_q, err_q;
  logic [7:0] vheading, hheading;
  logic [3:0] vsquares, hsquares;
  logic legal, last, vphase;
  move_decode u_dec (
    .move(bus.move), .vheading(vheading), .vsquares(vsquares),
    .hheading(hheading), .hsquares(hsquares), .legal(legal)
  );
  assign last = idx == IDX_W'(NUM_MOVES - 1);
  assign vphase = state == VERT || state == WAIT_V;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      tour_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tour_done_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (bus.start_tour) begin
          idx <= '0;
          state <= VERT;
        end
        VERT: if (!legal) begin
          err_q <= 1'b1;
          idx <= '0;
          state <= IDLE;
        end else if (bus.clr_cmd_rdy) state <= WAIT_V;
        WAIT_V: if (bus.send_resp) state <= HORZ;
        HORZ: if (bus.clr_cmd_rdy) state <= WAIT_H;
        WAIT_H: if (bus.send_resp) begin
          tour_done_q <= last;
          idx <= last ? '0 : idx + 1'b1;
          state <= last ? IDLE : VERT;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.mv_indx = idx;
  assign bus.tour_done = tour_done_q;
  assign bus.err = err_q;
  assign bus.cmd = state == IDLE ? bus.cmd_UART :
                   vphase ? {MOVE, vheading, vsquares} : {MOVE_FAN, hheading, hsquares};
  // an illegal move must never raise cmd_rdy; the FSM leaves VERT on the next edge
  assign bus.cmd_rdy = state == IDLE ? bus.cmd_rdy_UART : state == VERT ? legal : state == HORZ;
  assign bus.clr_cmd_rdy_UART = state == IDLE && bus.clr_cmd_rdy;
  assign bus.resp = (state == IDLE || (state == WAIT_H && bus.send_resp && last)) ? ACK : MV_ACK;
endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb_tour_cmd_seq: randomized tours checked by a scoreboard against a dx/dy reference model
module tb_tour_cmd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tour_cmd_seq_if #(.IDX_W(5)) bus();
  tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  typedef struct packed {logic [15:0] cmd; logic tour; logic [4:0] idx;} exp_t;
  exp_t exp_q[$];
  int evt_q[$];
  logic [7:0] moves [24];
  int vectors = 0, miscompares = 0;
  int acc_cnt = 0, stall_at = -1;
  bit stalled = 1'b0;
  int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  assign bus.move = bus.mv_indx < 5'd24 ? moves[bus.mv_indx] : 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask
  function automatic int bitpos(input logic [7:0] m);
    int p = 0;
    for (int i = 0; i < 8; i++) if (m[i]) p = i;
    return p;
  endfunction
  function automatic logic [15:0] vcmd(input logic [7:0] m);
    int dy = dys[bitpos(m)];
    return {4'h2, dy > 0 ? 8'h00 : 8'h7F, 4'(dy < 0 ? -dy : dy)};
  endfunction
  function automatic logic [15:0] hcmd(input logic [7:0] m);
    int dx = dxs[bitpos(m)];
    return {4'h3, dx > 0 ? 8'hBF : 8'h3F, 4'(dx < 0 ? -dx : dx)};
  endfunction
  task automatic push_moves(input int from, input int to, input int evt);
    for (int k = from; k < to; k++) begin
      exp_q.push_back('{vcmd(moves[k]), 1'b1, 5'(k)});
      exp_q.push_back('{hcmd(moves[k]), 1'b1, 5'(k)});
    end
    if (evt >= 0) evt_q.push_back(evt);
  endtask
  task automatic rand_moves();
    for (int k = 0; k < 24; k++) moves[k] = 8'h01 << $urandom_range(0, 7);
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 bus.start_tour = 1'b1;
    @(posedge clk); #1 bus.start_tour = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 4000 && (exp_q.size() != 0 || evt_q.size() != 0); i++) @(negedge clk);
    chk("drain_timeout", exp_q.size() + evt_q.size(), 0);
    exp_q.delete();
    evt_q.delete();
    repeat (8) @(negedge clk);
  endtask
  task automatic wait_stall();
    for (int i = 0; i < 2000 && !stalled; i++) @(negedge clk);
    chk("stall_timeout", 32'(stalled), 1);
  endtask
  // cmd_proc model: accept each command, then report completion after a random delay
  initial begin
    int n;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.cmd_rdy && !rst) begin
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk); #2 bus.clr_cmd_rdy = 1'b0;
        acc_cnt++;
        if (acc_cnt == stall_at) begin
          stalled = 1'b1;
          while (stalled) begin @(posedge clk); #2; end
        end
        n = $urandom_range(0, 3);
        repeat (n) begin @(posedge clk); #2; end
        bus.send_resp = 1'b1;
        @(posedge clk); #2 bus.send_resp = 1'b0;
      end
    end
  end
  // UART wrapper model: drop cmd_rdy_UART once the command is consumed
  initial forever begin
    @(negedge clk);
    if (bus.clr_cmd_rdy_UART) begin @(posedge clk); #1 bus.cmd_rdy_UART = 1'b0; end
  end
  // monitor: pops the scoreboard whenever a command is accepted or an event pulses
  initial begin
    logic [7:0] prev_resp;
    bit just_acc;
    exp_t e;
    int k;
    prev_resp = 8'h00;
    just_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) just_acc = 1'b0;
      else begin
        if (just_acc) chk("rdy_drop", 32'(bus.cmd_rdy), 0);
        just_acc = 1'b0;
        if (bus.cmd_rdy && bus.clr_cmd_rdy) begin
          just_acc = 1'b1;
          if (exp_q.size() == 0) flag("extra_cmd");
          else begin
            e = exp_q.pop_front();
            chk("cmd", 32'(bus.cmd), 32'(e.cmd));
            chk("resp_at_cmd", 32'(bus.resp), e.tour ? 32'h5A : 32'hA5);
            chk("clr_uart", 32'(bus.clr_cmd_rdy_UART), e.tour ? 0 : 1);
            if (e.tour) chk("mv_indx", 32'(bus.mv_indx), 32'(e.idx));
          end
        end
        if (bus.tour_done) begin
          if (evt_q.size() == 0) flag("extra_tour_done");
          else begin
            k = evt_q.pop_front();
            chk("done_kind", 32'(k), 0);
            chk("done_resp", 32'(prev_resp), 32'hA5);
            chk("done_idx", 32'(bus.mv_indx), 0);
          end
        end
        if (bus.err) begin
          if (evt_q.size() == 0) flag("extra_err");
          else begin
            k = evt_q.pop_front();
            chk("err_kind", 32'(k), 1);
            chk("err_idx", 32'(bus.mv_indx), 0);
            chk("err_rdy", 32'(bus.cmd_rdy), 0);
          end
        end
      end
      prev_resp = bus.resp;
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] m;
    int k;
    bus.start_tour = 1'b0;
    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    rand_moves();
    repeat (2) @(negedge clk);
    chk("rst_idx", 32'(bus.mv_indx), 0);
    chk("rst_done", 32'(bus.tour_done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_clr_uart", 32'(bus.clr_cmd_rdy_UART), 0);
    chk("rst_rdy", 32'(bus.cmd_rdy), 0);
    chk("rst_resp", 32'(bus.resp), 32'hA5);
    @(posedge clk); #1 rst = 1'b0;
    // idle pass-through
    exp_q.push_back('{16'h7000, 1'b0, 5'd0});
    @(posedge clk); #1;
    bus.cmd_UART = 16'h7000;
    bus.cmd_rdy_UART = 1'b1;
    drain();
    // directed first moves, model for the rest
    rand_moves();
    moves[0] = 8'h01;
    moves[1] = 8'h10;
    moves[2] = 8'h08;
    exp_q.push_back('{16'h2002, 1'b1, 5'd0});
    exp_q.push_back('{16'h3BF1, 1'b1, 5'd0});
    exp_q.push_back('{16'h27F2, 1'b1, 5'd1});
    exp_q.push_back('{16'h33F1, 1'b1, 5'd1});
    push_moves(2, 24, 0);
    acc_cnt = 0;
    pulse_start();
    drain();
    // random full tours
    repeat (3) begin
      rand_moves();
      push_moves(0, 24, 0);
      acc_cnt = 0;
      pulse_start();
      drain();
    end
    // illegal move at index 0
    moves[0] = 8'h03;
    push_moves(0, 0, 1);
    pulse_start();
    drain();
    // random illegal move mid-tour
    rand_moves();
    k = $urandom_range(1, 23);
    do m = 8'($urandom); while ($countones(m) == 1);
    moves[k] = m;
    push_moves(0, k, 1);
    acc_cnt = 0;
    pulse_start();
    drain();
    // start_tour while waiting on the first vertical command is ignored
    rand_moves();
    push_moves(0, 24, 0);
    acc_cnt = 0;
    stall_at = 1;
    pulse_start();
    wait_stall();
    pulse_start();
    stall_at = -1;
    stalled = 1'b0;
    drain();
    // UART command raised mid-tour waits for the return to IDLE
    rand_moves();
    push_moves(0, 24, 0);
    m = 8'($urandom);
    exp_q.push_back('{{8'h5C, m}, 1'b0, 5'd0});
    acc_cnt = 0;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    bus.cmd_UART = {8'h5C, m};
    bus.cmd_rdy_UART = 1'b1;
    drain();
    // reset while in WAIT_H of move 7
    rand_moves();
    push_moves(0, 8, -1);
    acc_cnt = 0;
    stall_at = 16;
    pulse_start();
    wait_stall();
    chk("pre_rst_idx", 32'(bus.mv_indx), 7);
    chk("pre_rst_resp", 32'(bus.resp), 32'h5A);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idx", 32'(bus.mv_indx), 0);
    chk("mid_rst_rdy", 32'(bus.cmd_rdy), 0);
    chk("mid_rst_resp", 32'(bus.resp), 32'hA5);
    @(posedge clk); #1 rst = 1'b0;
    stall_at = -1;
    stalled = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_rdy", 32'(bus.cmd_rdy), 0);
    end
    chk("post_rst_idx", 32'(bus.mv_indx), 0);
    drain();
    // service resumes normally after the abort
    rand_moves();
    push_moves(0, 24, 0);
    acc_cnt = 0;
    pulse_start();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
